// File: rtl/xoodoo_perm_ctrl_sca.sv
// ----------------------------------------------------------------------------
// xoodoo_perm_ctrl_sca
//
// Sequencer for a masked (two-share, DOM first-order) single-round Xoodoo
// core. It captures a two-share 384-bit state and then runs NROUNDS rounds.
// Each round issues the shares, the one-hot round token and one fresh 384-bit
// randomness word to the core. After ROUND_LAT cycles it takes the core's
// output shares and shifted token back. Once the captured token reaches
// bit 12, the two result shares are presented until the consumer takes them.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// Producers keep payload stable while valid is high and ready is low.
// rdi_ready is a consume strobe: it is high in exactly the cycle rdi is taken.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          input shares handshake (in_ready = idle)
//   in_share0/in_share1        input state shares
//   out_valid/out_ready        result handshake
//   out_share0/out_share1      result shares, zero unless out_valid
//   rdi_valid/rdi_ready/rdi    fresh randomness from the PRNG
//   core_in0/core_in1          shares to the round core
//   core_rdi/core_rdi_en       randomness and its one-cycle enable to the core
//   core_j_in                  one-hot round token to the core
//   core_out0/core_out1        shares from the round core
//   core_j_out                 shifted token from the round core
//   err                        sticky token-consistency error
//   dbg_state_o                current FSM state (0 idle, 1 issue, 2 wait, 3 done)
// ----------------------------------------------------------------------------
module xoodoo_perm_ctrl_sca #(
    parameter int NROUNDS   = 12,
    parameter int ROUND_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [383:0] in_share0,
    input  logic [383:0] in_share1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [383:0] out_share0,
    output logic [383:0] out_share1,
    input  logic         rdi_valid,
    output logic         rdi_ready,
    input  logic [383:0] rdi,
    output logic [383:0] core_in0,
    output logic [383:0] core_in1,
    output logic [383:0] core_rdi,
    output logic         core_rdi_en,
    output logic [12:0]  core_j_in,
    input  logic [383:0] core_out0,
    input  logic [383:0] core_out1,
    input  logic [12:0]  core_j_out,
    output logic         err,
    output logic [1:0]   dbg_state_o
);

    // The wait counter is loaded with ROUND_LAT-1 and counts down to zero.
    localparam int CNT_W = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROUND_LAT - 1);
    // Starting lower in the token makes bit 12 arrive after exactly NROUNDS
    // captures, and it selects the last NROUNDS round constants in the core.
    localparam logic [12:0] START_TOKEN = 13'd1 << (12 - NROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [383:0]     sh0_q;
    logic [383:0]     sh1_q;
    logic [12:0]      token_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic [12:0] token_exp;
    logic        issue_go;
    logic        core_active;
    logic        st_done;

    assign token_exp   = {token_q[11:0], 1'b0};
    assign issue_go    = (state_q == S_ISSUE) && rdi_valid;
    assign core_active = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign st_done     = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh0_q   <= '0;
            sh1_q   <= '0;
            token_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sh0_q   <= in_share0;
                        sh1_q   <= in_share1;
                        token_q <= START_TOKEN;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A round never starts without fresh randomness.
                    if (rdi_valid) begin
                        cnt_q   <= CNT_INIT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        sh0_q   <= core_out0;
                        sh1_q   <= core_out1;
                        token_q <= core_j_out;
                        err_q   <= err_q | (core_j_out != token_exp);
                        // Termination follows the captured token even when it
                        // is malformed; the mismatch is only flagged.
                        state_q <= core_j_out[12] ? S_DONE : S_ISSUE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        sh0_q   <= '0;
                        sh1_q   <= '0;
                        token_q <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state. Share buses are gated to zero
    // whenever they carry no meaning, and the two shares stay on separate paths.
    assign in_ready    = (state_q == S_IDLE);
    assign rdi_ready   = issue_go;
    assign core_rdi_en = issue_go;
    assign core_rdi    = (state_q == S_ISSUE) ? rdi : '0;
    assign core_in0    = core_active ? sh0_q : '0;
    assign core_in1    = core_active ? sh1_q : '0;
    assign core_j_in   = core_active ? token_q : '0;
    assign out_valid   = st_done;
    assign out_share0  = st_done ? sh0_q : '0;
    assign out_share1  = st_done ? sh1_q : '0;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule
